// File: rtl/stream_muxn.sv
// N-to-1 valid/ready stream multiplexer with a registered output stage.
// Define STREAM_MUXN_RR_EN for round-robin arbitration; otherwise lowest index wins.
module stream_muxn #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  localparam int unsigned CW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      out_chan,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_chan_q, out_chan_d;

  logic             load;
  logic             grant_vld;
  logic [CW-1:0]    grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             xfer_in;

  assign load = !out_valid_q || out_ready;

`ifdef STREAM_MUXN_RR_EN
  localparam logic [CW:0] NumCh = (CW+1)'(N);

  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW:0]   scan_idx;

  // Scan starts at the pointer and wraps from N-1 back to 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_q} + (CW+1)'(k);
      if (scan_idx >= NumCh) scan_idx = scan_idx - NumCh;
      if (!grant_vld && in_valid[scan_idx[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[CW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer_in) ptr_d = (grant_idx == CW'(N - 1)) ? '0 : grant_idx + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!grant_vld && in_valid[k]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(k);
      end
    end
  end
`endif

  // Gating with reset_n keeps every in_ready low while reset is held.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = reset_n && load && grant_vld && (grant_idx == CW'(i));
      if (grant_idx == CW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign xfer_in = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (load) begin
      if (xfer_in) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_chan_d  = grant_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: doc/stream_muxn.md
STREAM_MUXN -- requirements
Module: stream_muxn

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, legal range 1..64.
REQ-002 Parameter N, default 4: input channel count, legal range 2..16.
REQ-003 Localparam CW = clog2(N): channel-index width.
REQ-004 clk  input  1: single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  N: bit i is set when channel i presents data.
REQ-007 in_data  input  N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  N: bit i is set when channel i is accepted this cycle.
REQ-009 out_valid  output  1: output register holds a valid word.
REQ-010 out_data  output  WIDTH: registered selected word.
REQ-011 out_chan  output  CW: registered index of the source channel of out_data.
REQ-012 out_ready  input  1: downstream accepts the word this cycle.

Function
REQ-013 A transfer occurs on any channel or on the output when its valid and ready are both high at the rising clk edge.
REQ-014 load = !out_valid || out_ready; the output register accepts a new word only when load is high.
REQ-015 Grant is combinational; at most one grant[i] is high, and only when in_valid[i] is high.
REQ-016 in_ready[i] = grant[i] && load; no in_ready bit depends combinationally on in_data.
REQ-017 On an input transfer from channel g, out_data <= in_data[g], out_chan <= g and out_valid <= 1 at the next edge (latency 1 cycle).
REQ-018 When load is high and no in_valid bit is set, out_valid <= 0, and out_data/out_chan hold their previous values.
REQ-019 When out_valid=1 and out_ready=0, out_valid, out_data and out_chan hold, and all in_ready bits are 0.
REQ-020 Simultaneous output drain and input accept in the same cycle sustain one word per cycle with no bubble.
REQ-021 An in_valid that deasserts before its grant is dropped silently, with no state change.
REQ-022 Full throughput: with all channels valid and out_ready held at 1, one word transfers every cycle.

Reset
REQ-023 While reset_n=0: out_valid=0, out_data=0, out_chan=0, round-robin pointer=0, and all in_ready bits read 0.
REQ-024 Reset asserted mid-transfer discards the held word, and no transfer is reported in that cycle.
REQ-025 Reset deassertion is synchronised externally; the first transfer can occur on the first edge after release.

Configuration
REQ-026 With macro STREAM_MUXN_RR_EN defined, grant is round-robin:
- the search starts at pointer ptr and wraps from N-1 to 0;
- after an input transfer from channel g, ptr <= (g+1) mod N;
- ptr is unchanged when no input transfer occurs.
REQ-027 With STREAM_MUXN_RR_EN undefined, grant is fixed priority (lowest-indexed valid channel wins), and no pointer register exists.

Verification
REQ-028 Reset: hold reset_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_chan=0, in_ready=0.
REQ-029 Single channel: in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_chan=2.
REQ-030 Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid=4'b1111 -> in_ready=0 and output stable all 5 cycles.
REQ-031 RR fairness (STREAM_MUXN_RR_EN defined): in_valid=4'b1111, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
REQ-032 Fixed priority (STREAM_MUXN_RR_EN undefined): same stimulus as REQ-031 -> out_chan=0 every cycle.
REQ-033 Reset mid-stream: assert reset_n=0 while out_valid=1 -> out_valid=0 immediately; after release, RR restarts from channel 0.
